// File: rtl/pspin_pkt_alloc_mc.sv
// Multi-class packet-buffer allocator with per-class free rings for L2 packet memory.
// Optional macro PSPIN_PKT_ALLOC_SPILL_EN: spill to the next larger non-empty class.
module pspin_pkt_alloc_mc #(
  parameter int unsigned NUM_CLASS       = 6,
  parameter int unsigned MIN_SLOT_SIZE   = 64,
  parameter int unsigned SLOT_COUNT_LOG2 = 8,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned TAG_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BUF_START = 32'h1c100000,
  parameter longint unsigned BUF_SIZE    = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_WIDTH-1:0]  pkt_tag_i,
  input  logic [LEN_WIDTH-1:0]  pkt_len_i,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic                  feedback_valid_i,
  output logic                  feedback_ready_o,
  input  logic [ADDR_WIDTH-1:0] feedback_her_addr_i,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic [LEN_WIDTH-1:0]  write_len_o,
  output logic [TAG_WIDTH-1:0]  write_tag_o,
  output logic                  write_valid_o,
  input  logic                  write_ready_i,
  output logic                  init_done_o,
  output logic [NUM_CLASS*(SLOT_COUNT_LOG2+1)-1:0] free_count_o,
  output logic [31:0]           dropped_pkts_o,
  output logic [31:0]           bad_feedback_o
);
  localparam int unsigned SLOT_COUNT = 1 << SLOT_COUNT_LOG2;
  localparam int unsigned CW = SLOT_COUNT_LOG2 + 1;
  localparam int MIN_LOG2 = $clog2(MIN_SLOT_SIZE);
  localparam longint unsigned NEED =
    64'(SLOT_COUNT) * 64'(MIN_SLOT_SIZE) * ((64'd1 << NUM_CLASS) - 64'd1);

  if (NEED > BUF_SIZE) begin : g_size_chk
    $error("slot regions exceed BUF_SIZE");
  end

  function automatic logic [ADDR_WIDTH-1:0] reg_base(input int i);
    longint unsigned o;
    o = 64'(SLOT_COUNT) * 64'(MIN_SLOT_SIZE) * ((64'd1 << i) - 64'd1);
    return BUF_START + ADDR_WIDTH'(o);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] reg_size(input int i);
    return ADDR_WIDTH'((64'(SLOT_COUNT) * 64'(MIN_SLOT_SIZE)) << i);
  endfunction

  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;

  logic [SLOT_COUNT_LOG2-1:0] init_cnt_q, init_cnt_d;
  logic [SLOT_COUNT_LOG2-1:0] ring_mem [NUM_CLASS][SLOT_COUNT];
  logic [SLOT_COUNT_LOG2-1:0] head_q [NUM_CLASS];
  logic [SLOT_COUNT_LOG2-1:0] head_d [NUM_CLASS];
  logic [SLOT_COUNT_LOG2-1:0] tail_q [NUM_CLASS];
  logic [SLOT_COUNT_LOG2-1:0] tail_d [NUM_CLASS];
  logic [CW-1:0] count_q [NUM_CLASS];
  logic [CW-1:0] count_d [NUM_CLASS];

  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [LEN_WIDTH-1:0]  write_len_q, write_len_d;
  logic [TAG_WIDTH-1:0]  write_tag_q, write_tag_d;
  logic                  write_valid_q, write_valid_d;
  logic [31:0]           dropped_q, dropped_d;
  logic [31:0]           bad_q, bad_d;

  logic init_done, init_we;
  logic [ADDR_WIDTH-1:0] len_ext, alloc_addr, fb_off;
  logic fit_found, slot_found;
  int   fit_cls, sel_cls, fb_cls;
  logic pkt_acc, alloc, drop;
  logic fb_fire, fb_hit, fb_aligned, fb_full, push_ok, fb_bad;
  logic [SLOT_COUNT_LOG2-1:0] fb_idx;
  logic [NUM_CLASS-1:0] pop_en, push_en;

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_cnt_q == '1) state_d = RUN;
  end

  always_comb begin
    init_done = (state_q == RUN);
    init_we   = (state_q == INIT);
  end

  always_comb begin
    len_ext   = ADDR_WIDTH'(pkt_len_i);
    fit_found = 1'b0;
    fit_cls   = 0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (!fit_found && len_ext != '0 &&
          len_ext <= (ADDR_WIDTH'(MIN_SLOT_SIZE) << i)) begin
        fit_found = 1'b1;
        fit_cls   = i;
      end
    end
    slot_found = 1'b0;
    sel_cls    = 0;
    for (int i = 0; i < NUM_CLASS; i++) begin
`ifdef PSPIN_PKT_ALLOC_SPILL_EN
      if (fit_found && !slot_found && i >= fit_cls && count_q[i] != '0) begin
`else
      if (fit_found && i == fit_cls && count_q[i] != '0) begin
`endif
        slot_found = 1'b1;
        sel_cls    = i;
      end
    end
    alloc_addr = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (sel_cls == i)
        alloc_addr = reg_base(i) +
          (ADDR_WIDTH'(ring_mem[i][head_q[i]]) << (MIN_LOG2 + i));
    end
    pkt_ready_o = init_done && (!write_valid_q || write_ready_i);
    pkt_acc     = pkt_valid_i && pkt_ready_o;
    alloc       = pkt_acc && slot_found;
    drop        = pkt_acc && !slot_found;
  end

  // Free path: range decode, alignment and double-free (full ring) checks
  always_comb begin
    fb_hit     = 1'b0;
    fb_cls     = 0;
    fb_aligned = 1'b0;
    fb_full    = 1'b0;
    fb_idx     = '0;
    fb_off     = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (!fb_hit && feedback_her_addr_i >= reg_base(i) &&
          (feedback_her_addr_i - reg_base(i)) < reg_size(i)) begin
        fb_hit     = 1'b1;
        fb_cls     = i;
        fb_off     = feedback_her_addr_i - reg_base(i);
        fb_aligned = (fb_off & ((ADDR_WIDTH'(1) << (MIN_LOG2 + i)) -
                     ADDR_WIDTH'(1))) == '0;
        fb_idx     = SLOT_COUNT_LOG2'(fb_off >> (MIN_LOG2 + i));
        fb_full    = (count_q[i] == CW'(SLOT_COUNT));
      end
    end
    fb_fire = feedback_valid_i && init_done;
    push_ok = fb_fire && fb_hit && fb_aligned && !fb_full;
    fb_bad  = fb_fire && !push_ok;
    for (int i = 0; i < NUM_CLASS; i++) begin
      pop_en[i]  = alloc && (sel_cls == i);
      push_en[i] = push_ok && (fb_cls == i);
    end
  end

  always_comb begin
    init_cnt_d = init_we ? init_cnt_q + SLOT_COUNT_LOG2'(1) : init_cnt_q;
    for (int i = 0; i < NUM_CLASS; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      if (pop_en[i])  head_d[i] = head_q[i] + SLOT_COUNT_LOG2'(1);
      if (push_en[i]) tail_d[i] = tail_q[i] + SLOT_COUNT_LOG2'(1);
      if (pop_en[i] && !push_en[i]) count_d[i] = count_q[i] - CW'(1);
      if (push_en[i] && !pop_en[i]) count_d[i] = count_q[i] + CW'(1);
      if (init_we && init_cnt_q == '1) count_d[i] = CW'(SLOT_COUNT);
    end
    write_addr_d  = write_addr_q;
    write_len_d   = write_len_q;
    write_tag_d   = write_tag_q;
    write_valid_d = write_valid_q && !write_ready_i;
    if (alloc) begin
      write_addr_d  = alloc_addr;
      write_len_d   = pkt_len_i;
      write_tag_d   = pkt_tag_i;
      write_valid_d = 1'b1;
    end
    dropped_d = dropped_q;
    if (drop && dropped_q != '1) dropped_d = dropped_q + 32'd1;
    bad_d = bad_q;
    if (fb_bad && bad_q != '1) bad_d = bad_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q    <= '0;
      head_q        <= '{default: '0};
      tail_q        <= '{default: '0};
      count_q       <= '{default: '0};
      write_addr_q  <= '0;
      write_len_q   <= '0;
      write_tag_q   <= '0;
      write_valid_q <= 1'b0;
      dropped_q     <= '0;
      bad_q         <= '0;
    end else begin
      init_cnt_q    <= init_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      write_addr_q  <= write_addr_d;
      write_len_q   <= write_len_d;
      write_tag_q   <= write_tag_d;
      write_valid_q <= write_valid_d;
      dropped_q     <= dropped_d;
      bad_q         <= bad_d;
    end
  end

  // Ring storage holds slot indices; addresses are rebuilt from the class map
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (init_we)         ring_mem[i][init_cnt_q] <= init_cnt_q;
      else if (push_en[i]) ring_mem[i][tail_q[i]]  <= fb_idx;
    end
  end

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_fc
    assign free_count_o[g*CW +: CW] = count_q[g];
  end

  assign feedback_ready_o = init_done;
  assign init_done_o      = init_done;
  assign write_addr_o     = write_addr_q;
  assign write_len_o      = write_len_q;
  assign write_tag_o      = write_tag_q;
  assign write_valid_o    = write_valid_q;
  assign dropped_pkts_o   = dropped_q;
  assign bad_feedback_o   = bad_q;
endmodule

// File: tb/tb_pspin_pkt_alloc_mc.sv
// Directed self-checking bench for pspin_pkt_alloc_mc (default parameters).
module tb_pspin_pkt_alloc_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_tag_i = '0;
  logic [19:0] pkt_len_i = '0;
  logic        pkt_valid_i = 1'b0;
  logic        pkt_ready_o;
  logic        feedback_valid_i = 1'b0;
  logic        feedback_ready_o;
  logic [31:0] feedback_her_addr_i = '0;
  logic [31:0] write_addr_o;
  logic [19:0] write_len_o;
  logic [31:0] write_tag_o;
  logic        write_valid_o;
  logic        write_ready_i = 1'b1;
  logic        init_done_o;
  logic [53:0] free_count_o;
  logic [31:0] dropped_pkts_o;
  logic [31:0] bad_feedback_o;

  int n_eval = 0;
  int n_fail = 0;

  pspin_pkt_alloc_mc dut (
    .clk(clk), .rst(rst),
    .pkt_tag_i(pkt_tag_i), .pkt_len_i(pkt_len_i),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .feedback_valid_i(feedback_valid_i),
    .feedback_ready_o(feedback_ready_o),
    .feedback_her_addr_i(feedback_her_addr_i),
    .write_addr_o(write_addr_o), .write_len_o(write_len_o),
    .write_tag_o(write_tag_o), .write_valid_o(write_valid_o),
    .write_ready_i(write_ready_i), .init_done_o(init_done_o),
    .free_count_o(free_count_o),
    .dropped_pkts_o(dropped_pkts_o),
    .bad_feedback_o(bad_feedback_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fc(input int i);
    return 64'(free_count_o[i*9 +: 9]);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] len, input logic [31:0] tag);
    pkt_len_i   = len;
    pkt_tag_i   = tag;
    pkt_valid_i = 1'b1;
    tick();
    pkt_valid_i = 1'b0;
  endtask

  task automatic free_addr(input logic [31:0] a);
    feedback_her_addr_i = a;
    feedback_valid_i    = 1'b1;
    tick();
    feedback_valid_i    = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] a5;
    repeat (3) tick();
    check("rst_init_done", 64'(init_done_o), 0);
    check("rst_wvalid", 64'(write_valid_o), 0);
    check("rst_fc0", fc(0), 0);
    check("rst_pkt_ready", 64'(pkt_ready_o), 0);
    check("rst_fb_ready", 64'(feedback_ready_o), 0);
    check("rst_dropped", 64'(dropped_pkts_o), 0);
    rst = 1'b0;
    n = 0;
    while (!init_done_o && n < 400) begin
      tick();
      n++;
    end
    check("init_cycles", 64'(n), 256);
    for (int i = 0; i < 6; i++) check("init_fc", fc(i), 256);
    check("init_fb_ready", 64'(feedback_ready_o), 1);

    send(20'd64, 32'hA);
    check("p64_valid", 64'(write_valid_o), 1);
    check("p64_addr", 64'(write_addr_o), 64'h1c100000);
    check("p64_len", 64'(write_len_o), 64);
    check("p64_tag", 64'(write_tag_o), 64'hA);
    send(20'd65, 32'hB);
    check("p65_addr", 64'(write_addr_o), 64'h1c104000);
    send(20'd1518, 32'hC);
    check("p1518_addr", 64'(write_addr_o), 64'h1c17C000);
    check("p1518_len", 64'(write_len_o), 1518);
    check("fc0_255", fc(0), 255);
    check("fc5_255", fc(5), 255);
    tick();
    check("idle_clear", 64'(write_valid_o), 0);

    send(20'd2049, 32'hD);
    check("big_novalid", 64'(write_valid_o), 0);
    send(20'd0, 32'hE);
    check("zero_novalid", 64'(write_valid_o), 0);
    check("dropped_2", 64'(dropped_pkts_o), 2);

    for (int k = 0; k < 255; k++) send(20'd64, 32'(k));
    check("last_c0_addr", 64'(write_addr_o), 64'h1c103FC0);
    check("fc0_empty", fc(0), 0);
    send(20'd64, 32'h77);
`ifdef PSPIN_PKT_ALLOC_SPILL_EN
    check("spill_valid", 64'(write_valid_o), 1);
    check("spill_addr", 64'(write_addr_o), 64'h1c104080);
    check("spill_fc1", fc(1), 254);
    check("spill_dropped", 64'(dropped_pkts_o), 2);
    a5 = 32'h1c104100;
`else
    check("strict_valid", 64'(write_valid_o), 0);
    check("strict_dropped", 64'(dropped_pkts_o), 3);
    check("strict_fc1", fc(1), 255);
    a5 = 32'h1c104080;
`endif
    tick();

    write_ready_i = 1'b0;
    send(20'd128, 32'h55);
    check("stall_valid0", 64'(write_valid_o), 1);
    check("stall_addr0", 64'(write_addr_o), 64'(a5));
    pkt_len_i   = 20'd256;
    pkt_tag_i   = 32'h66;
    pkt_valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_valid", 64'(write_valid_o), 1);
      check("stall_addr", 64'(write_addr_o), 64'(a5));
      check("stall_tag", 64'(write_tag_o), 64'h55);
      check("stall_len", 64'(write_len_o), 128);
      check("stall_ready", 64'(pkt_ready_o), 0);
    end
    write_ready_i = 1'b1;
    #1;
    check("release_ready", 64'(pkt_ready_o), 1);
    tick();
    pkt_valid_i = 1'b0;
    check("next_valid", 64'(write_valid_o), 1);
    check("next_addr", 64'(write_addr_o), 64'h1c10C000);
    check("next_tag", 64'(write_tag_o), 64'h66);
    tick();
    check("next_clear", 64'(write_valid_o), 0);

    free_addr(32'h1c100040);
    check("free_fc0", fc(0), 1);
    check("free_bad0", 64'(bad_feedback_o), 0);
    free_addr(32'h1c100020);
    check("unaligned_bad", 64'(bad_feedback_o), 1);
    free_addr(32'h1c300000);
    check("outside_bad", 64'(bad_feedback_o), 2);
    free_addr(32'h1c11C000);
    check("double_bad", 64'(bad_feedback_o), 3);
    check("double_fc3", fc(3), 256);
    check("bad_fc0", fc(0), 1);

    feedback_her_addr_i = 32'h1c100080;
    feedback_valid_i    = 1'b1;
    send(20'd64, 32'h99);
    feedback_valid_i    = 1'b0;
    check("sim_addr", 64'(write_addr_o), 64'h1c100040);
    check("sim_fc0", fc(0), 1);
    check("sim_bad", 64'(bad_feedback_o), 3);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_done", 64'(init_done_o), 0);
    check("mid_rst_fc0", fc(0), 0);
    check("mid_rst_drop", 64'(dropped_pkts_o), 0);
    check("mid_rst_bad", 64'(bad_feedback_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end
endmodule
